mat_result_streamer: RTL and testbench

MAT_RESULT_STREAMER -- requirements
Module: mat_result_streamer

---
 rtl/mat_pkg.sv | 10 +
 rtl/mat_idx_counter.sv | 36 +++
 rtl/mat_result_streamer.sv | 65 ++++++
 tb/tb_mat_result_streamer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// mat_pkg: shared state encoding, default sizes and index-width helper for the matrix streamer
package mat_pkg;
  typedef enum logic {IDLE, STREAM} state_t;
  localparam int M_DEF = 8;
  localparam int P_DEF = 8;
  localparam int DW_DEF = 16;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mat_idx_counter.sv
// mat_idx_counter: row-major row/column sequencer for an M x P matrix
module mat_idx_counter import mat_pkg::*; #(
  parameter int M = M_DEF,
  parameter int P = P_DEF,
  localparam int RW = idx_w(M),
  localparam int CW = idx_w(P)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          row_last,
  output logic          last
);
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  always_comb begin
    row_last = col_q == CW'(P - 1);
    last = row_last && row_q == RW'(M - 1);
    col_d = clear || (advance && row_last) ? '0 : advance ? col_q + 1'b1 : col_q;
    row_d = clear || (advance && last) ? '0 : advance && row_last ? row_q + 1'b1 : row_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
  assign row = row_q;
  assign col = col_q;
endmodule

// File: rtl/mat_result_streamer.sv
// mat_result_streamer: captures a packed M x P matrix and streams its elements in row-major order
module mat_result_streamer import mat_pkg::*; #(
  parameter int M = M_DEF,
  parameter int P = P_DEF,
  parameter int DATA_WIDTH = DW_DEF,
  localparam int RW = idx_w(M),
  localparam int CW = idx_w(P),
  localparam int MW = M * P * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MW-1:0]         in_mat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [RW-1:0]         out_row,
  output logic [CW-1:0]         out_col,
  output logic                  out_row_last,
  output logic                  out_last,
  output logic                  busy
);
  state_t state_q, state_d;
  logic [MW-1:0] mat_q, mat_d;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic row_last, last, in_fire, out_fire;
  mat_idx_counter #(.M(M), .P(P)) u_idx (
    .clk(clk),
    .rst_n(rst_n),
    .clear(in_fire),
    .advance(out_fire),
    .row(row),
    .col(col),
    .row_last(row_last),
    .last(last)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mat_q <= '0;
    end else begin
      state_q <= state_d;
      mat_q <= mat_d;
    end
  end
  // a new matrix accepted on the final beat keeps STREAM with no bubble
  always_comb begin
    state_d = in_fire ? STREAM : out_fire && last ? IDLE : state_q;
    mat_d = in_fire ? in_mat : mat_q;
  end
  always_comb begin
    busy = state_q == STREAM;
    out_valid = busy;
    out_fire = out_valid && out_ready;
    in_ready = rst_n && (!busy || (out_fire && last));
    in_fire = in_valid && in_ready;
    out_row = row;
    out_col = col;
    out_row_last = out_valid && row_last;
    out_last = out_valid && last;
    out_data = out_valid ? mat_q[(int'(row) * P + int'(col)) * DATA_WIDTH +: DATA_WIDTH] : '0;
  end
endmodule

// File: tb/tb_mat_result_streamer.sv
// tb_mat_result_streamer: directed, table-driven and randomized checks of the matrix streamer
module tb_mat_result_streamer;
  localparam int M = 2;
  localparam int P = 2;
  localparam int DW = 16;
  typedef struct {logic [DW-1:0] d; int r; int c;} beat_t;
  typedef struct {logic rdy; logic v; logic [DW-1:0] d; int r; int c; logic rl; logic l;} vec_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_row_last, out_last, busy;
  logic [M*P*DW-1:0] in_mat = '0;
  logic [DW-1:0] out_data;
  logic [0:0] out_row, out_col;
  logic b_in_valid = 0, b_out_ready = 0;
  logic b_in_ready, b_out_valid, b_out_row_last, b_out_last, b_busy;
  logic [DW-1:0] b_in_mat = '0, b_out_data;
  logic [0:0] b_out_row, b_out_col;
  int total = 0, bad = 0;
  beat_t q[$];
  beat_t bt;
  vec_t tbl[8];
  logic [M*P*DW-1:0] mat1, mat2;
  logic ev, er;

  always #5 clk = ~clk;

  mat_result_streamer #(.M(M), .P(P), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mat(in_mat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_row_last(out_row_last), .out_last(out_last), .busy(busy)
  );

  mat_result_streamer #(.M(1), .P(1), .DATA_WIDTH(DW)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mat(b_in_mat),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_row(b_out_row),
    .out_col(b_out_col), .out_row_last(b_out_row_last), .out_last(b_out_last), .busy(b_busy)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string t, input logic [DW-1:0] d, input int r, input int c);
    chk({t, "_valid"}, out_valid, 1);
    chk({t, "_data"}, out_data, d);
    chk({t, "_row"}, out_row, r);
    chk({t, "_col"}, out_col, c);
    chk({t, "_row_last"}, out_row_last, c == P - 1);
    chk({t, "_last"}, out_last, r == M - 1 && c == P - 1);
  endtask

  task automatic load(input logic [M*P*DW-1:0] m);
    in_mat = m;
    in_valid = 1;
    @(negedge clk);
    chk("load_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
  endtask

  initial begin
    mat1 = {16'h0080, 16'hFF00, 16'h0200, 16'h0100};
    mat2 = {4{16'h7FFF}};
    tbl[0] = '{1'b1, 1'b1, 16'h0100, 0, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'h0200, 0, 1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h0200, 0, 1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 16'h0200, 0, 1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 16'h0200, 0, 1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'hFF00, 1, 0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 16'h0080, 1, 1, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 16'h0000, 0, 0, 1'b0, 1'b0};

    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_valid", out_valid, 0);
    tick();

    out_ready = 1;
    load(mat1);
    for (int k = 0; k < 4; k++) begin
      in_mat = {$urandom, $urandom};
      @(negedge clk);
      beat("b34", mat1[k*DW+:DW], k / 2, k % 2);
      tick();
    end
    @(negedge clk);
    chk("b34_idle_valid", out_valid, 0);
    chk("b34_idle_busy", busy, 0);
    chk("b34_idle_in_ready", in_ready, 1);
    tick();

    load(mat1);
    foreach (tbl[k]) begin
      out_ready = tbl[k].rdy;
      @(negedge clk);
      chk("t35_valid", out_valid, tbl[k].v);
      chk("t35_row_last", out_row_last, tbl[k].rl);
      chk("t35_last", out_last, tbl[k].l);
      if (tbl[k].v) begin
        chk("t35_data", out_data, tbl[k].d);
        chk("t35_row", out_row, tbl[k].r);
        chk("t35_col", out_col, tbl[k].c);
      end
      tick();
    end

    out_ready = 1;
    in_mat = mat1;
    in_valid = 1;
    @(negedge clk);
    chk("b36_load_ready", in_ready, 1);
    tick();
    in_mat = mat2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      beat("b36", k < 4 ? mat1[k*DW+:DW] : mat2[(k-4)*DW+:DW], (k % 4) / 2, k % 2);
      chk("b36_in_ready", in_ready, k == 3 || k == 7);
      tick();
      if (k == 3) in_valid = 0;
    end
    @(negedge clk);
    chk("b36_end_valid", out_valid, 0);
    tick();

    load(mat1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      beat("b37", mat1[k*DW+:DW], 0, k);
      tick();
    end
    rst_n = 0;
    @(negedge clk);
    chk("b37_rst_in_ready", in_ready, 0);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("b37_valid", out_valid, 0);
    chk("b37_busy", busy, 0);
    chk("b37_last", out_last, 0);
    chk("b37_in_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("b37_quiet_valid", out_valid, 0);
    end
    tick();

    for (int n = 0; n < 400; n++) begin
      in_valid = $urandom_range(0, 2) == 0;
      in_mat = {$urandom, $urandom};
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      ev = q.size() > 0;
      er = q.size() == 0 || (q.size() == 1 && out_ready);
      chk("rnd_valid", out_valid, ev);
      chk("rnd_busy", busy, ev);
      chk("rnd_in_ready", in_ready, er);
      if (ev) begin
        chk("rnd_data", out_data, q[0].d);
        chk("rnd_row", out_row, q[0].r);
        chk("rnd_col", out_col, q[0].c);
        chk("rnd_row_last", out_row_last, q[0].c == P - 1);
        chk("rnd_last", out_last, q[0].r == M - 1 && q[0].c == P - 1);
      end
      if (ev && out_ready) void'(q.pop_front());
      if (in_valid && er)
        for (int r = 0; r < M; r++)
          for (int c = 0; c < P; c++) begin
            bt.d = in_mat[(r*P+c)*DW+:DW];
            bt.r = r;
            bt.c = c;
            q.push_back(bt);
          end
      tick();
    end
    in_valid = 0;

    b_in_mat = 16'h8000;
    b_in_valid = 1;
    b_out_ready = 1;
    @(negedge clk);
    chk("b38_in_ready", b_in_ready, 1);
    tick();
    b_in_valid = 0;
    @(negedge clk);
    chk("b38_valid", b_out_valid, 1);
    chk("b38_data", b_out_data, 16'h8000);
    chk("b38_row", b_out_row, 0);
    chk("b38_col", b_out_col, 0);
    chk("b38_row_last", b_out_row_last, 1);
    chk("b38_last", b_out_last, 1);
    chk("b38_busy", b_busy, 1);
    tick();
    @(negedge clk);
    chk("b38_after_busy", b_busy, 0);
    chk("b38_after_valid", b_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
